puf_scan_master: RTL and testbench
==================================

// Module: puf_scan_master
// PURPOSE
//  On-chip master for the PUF scan interface (the driving end of clk/si/rstn/reset/puf_sel/length -> out/so).
//  Serially shifts a challenge into the selected PUF chain, arms and evaluates it, then samples the response bit.
//  Shifted-out chain contents are captured as a readback word. Sits between LA/Wishbone control logic and puf_top.
// PARAMETERS
//  CHAL_W    128  max challenge/chain length in bits (BR32/BR64/BR128 chains)
//  DIV       2    clk cycles per scan-clock half period (>=1)
//  EVAL_CYC  16   clk cycles between arm release and response sample (>=1)
// PORTS
//  clk            in   1       system clock
//  rstn           in   1       async active-low reset
//  start_i        in   1       start request; accepted only in IDLE
//  chal_i         in   CHAL_W  challenge, latched on accepted start
//  length_i       in   2       00=32, 01=64, 10/11=128 bits; latched on start
//  sel_i          in   2       PUF select; latched on start
//  busy_o         out  1       high from cycle after accept until response handshake
//  resp_valid_o   out  1       response available
//  resp_ready_i   in   1       consumer accepts response
//  resp_bit_o     out  1       PUF response bit; stable while resp_valid_o
//  readback_o     out  CHAL_W  bits shifted out of chain; [N-1:0] valid, upper bits 0
//  puf_clk_o      out  1       scan clock to PUF
//  puf_si_o       out  1       scan data to PUF
//  puf_rstn_o     out  1       PUF scan reset (active low)
//  puf_reset_o    out  1       PUF arm/reset pulse (active high)
//  puf_sel_o      out  2       registered copy of latched sel_i
//  puf_length_o   out  2       registered copy of latched length_i
//  puf_out_i      in   1       PUF response
//  puf_so_i       in   1       PUF scan out
// BEHAVIOUR
//  - Reset (rstn low, async): state IDLE; all outputs 0 (incl. puf_rstn_o, puf_clk_o, readback_o, resp_bit_o).
//  - First clk after rstn release: puf_rstn_o=1; stays 1 until next rstn assertion.
//  - States: IDLE -> SHIFT -> ARM -> EVAL -> SAMPLE -> DONE -> IDLE.
//  - IDLE: start_i=1 latches chal/length/sel, clears readback, loads bit count N; next state SHIFT.
//  - SHIFT: N bits, MSB first (chal[N-1] first). Per bit: puf_si_o updated with puf_clk_o low,
//    DIV cycles low, then DIV cycles high. On clk edge that drives puf_clk_o 0->1, puf_so_i is shifted
//    into readback LSB (readback <= {readback, so}). After Nth high phase, puf_clk_o returns 0; -> ARM.
//  - ARM: puf_reset_o=1 for exactly 2 cycles; -> EVAL.
//  - EVAL: puf_reset_o=0, wait EVAL_CYC cycles; -> SAMPLE.
//  - SAMPLE: capture puf_out_i into resp_bit_o (1 cycle; see CONFIGURATION); -> DONE.
//  - DONE: resp_valid_o=1; held, with resp_bit_o/readback_o stable, until resp_ready_i=1; then IDLE,
//    busy_o=0 the following cycle. resp_valid_o & resp_ready_i in same cycle completes transfer.
//  - Latency, accept to resp_valid_o: 1 + N*2*DIV + 2 + EVAL_CYC + S cycles (S=1, or 3 with majority).
//  - start_i ignored in every state but IDLE (incl. DONE); no queuing.
//  - Bit counter: 8 bits, counts down N-1..0; no wrap; N derived only from latched length.
//  - rstn asserted mid-operation: immediate abort, outputs to reset values; next start runs normally.
// CONFIGURATION
//  PUF_MAJORITY_EN defined: SAMPLE lasts 3 cycles, samples puf_out_i each cycle,
//    resp_bit_o = majority of 3 (S=3).
//  PUF_MAJORITY_EN undefined: single sample on SAMPLE cycle (S=1).
// STRUCTURE
//  - puf_pkg: state enum (IDLE..DONE), length codes, function len_to_bits(2b)->32/64/128.
//  - Sub-module puf_scan_clkgen: DIV counter emitting rise/fall ticks and puf_clk_o level; enabled in SHIFT.
//  - Top: FSM, challenge shift reg, readback shift reg, bit counter, eval counter, sampler.
// TESTING
//  1. DIV=2, length=00, chal[31:0]=0xA5A5_0F0F -> 32 puf_clk_o rises; si at each rise = 1,0,1,0,...; valid after 1+128+2+16+S.
//  2. Loopback model (so = chain tail of 64-bit shift reg), two 64-bit ops -> 2nd readback_o[63:0] = 1st chal.
//  3. puf_out_i=1, resp_ready_i low 10 cycles -> resp_valid_o/resp_bit_o=1 held; start_i pulses ignored, busy_o=1.
//  4. rstn low at bit 17 of SHIFT -> puf_clk_o=0, busy_o=0, puf_rstn_o=0 same cycle; rerun completes correctly.
//  5. length=11 -> 128 scan clocks, identical to length=10; puf_length_o=11.
//  6. puf_out_i 1,0,1 over SAMPLE -> resp_bit_o=1 with PUF_MAJORITY_EN; without, sample cycle value.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared types and helpers for the PUF scan master.
// Optional build macro: PUF_MAJORITY_EN (3-sample majority vote on the response bit).
package puf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_ARM,
        ST_EVAL,
        ST_SAMPLE,
        ST_DONE
    } puf_state_t;

    localparam logic [1:0] LEN_32  = 2'b00;
    localparam logic [1:0] LEN_64  = 2'b01;
    localparam logic [1:0] LEN_128 = 2'b10;

    localparam int unsigned ARM_CYC = 2;

`ifdef PUF_MAJORITY_EN
    localparam int unsigned SAMPLE_CYC = 3;
`else
    localparam int unsigned SAMPLE_CYC = 1;
`endif

    // Chain length in bits for a length code; 2'b11 aliases the 128-bit chain.
    function automatic logic [7:0] len_to_bits(input logic [1:0] len);
        case (len)
            LEN_32:  return 8'd32;
            LEN_64:  return 8'd64;
            LEN_128: return 8'd128;
            default: return 8'd128;
        endcase
    endfunction

endpackage

// File: rtl/puf_scan_clkgen.sv
// Scan clock generator: DIV clk cycles per half period, low phase first.
// Ticks flag the clk edge that will toggle the scan clock.
module puf_scan_clkgen #(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    output logic rise_tick,
    output logic fall_tick,
    output logic scan_clk
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic          half_end;

    assign half_end  = en && (cnt_q == CW'(DIV - 1));
    assign rise_tick = half_end && !scan_clk;
    assign fall_tick = half_end &&  scan_clk;

    // Half-period counter and scan clock level; parked low while disabled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q    <= '0;
            scan_clk <= 1'b0;
        end else if (!en) begin
            cnt_q    <= '0;
            scan_clk <= 1'b0;
        end else if (half_end) begin
            cnt_q    <= '0;
            scan_clk <= ~scan_clk;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/puf_scan_master.sv
// PUF scan master: shifts a challenge into the selected chain, arms and
// evaluates it, samples the response and returns the shifted-out chain.
// Optional build macro: PUF_MAJORITY_EN (response = majority of 3 samples).
module puf_scan_master
    import puf_pkg::*;
#(
    parameter int unsigned CHAL_W   = 128,
    parameter int unsigned DIV      = 2,
    parameter int unsigned EVAL_CYC = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start_i,
    input  logic [CHAL_W-1:0] chal_i,
    input  logic [1:0]        length_i,
    input  logic [1:0]        sel_i,
    output logic              busy_o,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic              resp_bit_o,
    output logic [CHAL_W-1:0] readback_o,
    output logic              puf_clk_o,
    output logic              puf_si_o,
    output logic              puf_rstn_o,
    output logic              puf_reset_o,
    output logic [1:0]        puf_sel_o,
    output logic [1:0]        puf_length_o,
    input  logic              puf_out_i,
    input  logic              puf_so_i
);

    puf_state_t        state_q, state_d;
    logic [CHAL_W-1:0] chal_sr;
    logic [7:0]        bit_cnt;
    logic [15:0]       cyc_q;
    logic              shift_done;
    logic              clk_en;
    logic              rise_tick, fall_tick;
    logic [7:0]        start_bits;
`ifdef PUF_MAJORITY_EN
    logic [1:0]        samp_q;
`endif

    assign start_bits = len_to_bits(length_i);
    // Challenge is pre-aligned so its bit N-1 sits at the MSB; si is always the MSB.
    assign puf_si_o   = chal_sr[CHAL_W-1];

    puf_scan_clkgen #(
        .DIV(DIV)
    ) u_clkgen (
        .clk       (clk),
        .rstn      (rstn),
        .en        (clk_en),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .scan_clk  (puf_clk_o)
    );

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_d      = state_q;
        busy_o       = 1'b1;
        resp_valid_o = 1'b0;
        puf_reset_o  = 1'b0;
        clk_en       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (start_i) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                // Clock generator stops once the last high phase has ended;
                // the remaining SHIFT cycle leaves puf_clk_o low.
                clk_en = !shift_done;
                if (shift_done) state_d = ST_ARM;
            end
            ST_ARM: begin
                puf_reset_o = 1'b1;
                if (cyc_q == 16'(ARM_CYC - 1)) state_d = ST_EVAL;
            end
            ST_EVAL: begin
                if (cyc_q == 16'(EVAL_CYC - 1)) state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (cyc_q == 16'(SAMPLE_CYC - 1)) state_d = ST_DONE;
            end
            ST_DONE: begin
                resp_valid_o = 1'b1;
                if (resp_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // PUF scan reset is released on the first clock after rstn deasserts.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) puf_rstn_o <= 1'b0;
        else       puf_rstn_o <= 1'b1;
    end

    // Datapath: request latch, challenge/readback shifting, bit and phase counters, sampler.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            chal_sr      <= '0;
            readback_o   <= '0;
            bit_cnt      <= '0;
            cyc_q        <= '0;
            shift_done   <= 1'b0;
            resp_bit_o   <= 1'b0;
            puf_sel_o    <= '0;
            puf_length_o <= '0;
`ifdef PUF_MAJORITY_EN
            samp_q       <= '0;
`endif
        end else begin
            if ((state_d != state_q) ||
                !(state_q inside {ST_ARM, ST_EVAL, ST_SAMPLE})) begin
                cyc_q <= '0;
            end else begin
                cyc_q <= cyc_q + 16'd1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        chal_sr      <= chal_i << (CHAL_W - 32'(start_bits));
                        readback_o   <= '0;
                        bit_cnt      <= start_bits - 8'd1;
                        shift_done   <= 1'b0;
                        puf_sel_o    <= sel_i;
                        puf_length_o <= length_i;
                    end
                end
                ST_SHIFT: begin
                    if (rise_tick) readback_o <= {readback_o[CHAL_W-2:0], puf_so_i};
                    if (fall_tick) begin
                        chal_sr <= {chal_sr[CHAL_W-2:0], 1'b0};
                        if (bit_cnt == 8'd0) shift_done <= 1'b1;
                        else                 bit_cnt    <= bit_cnt - 8'd1;
                    end
                end
                ST_SAMPLE: begin
`ifdef PUF_MAJORITY_EN
                    if (cyc_q == 16'd2) begin
                        resp_bit_o <= (samp_q[0] & samp_q[1]) |
                                      (samp_q[0] & puf_out_i) |
                                      (samp_q[1] & puf_out_i);
                    end else begin
                        samp_q[cyc_q[0]] <= puf_out_i;
                    end
`else
                    resp_bit_o <= puf_out_i;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_scan_master.sv
// Self-checking bench for puf_scan_master with a bit-level PUF chain model
// and a transaction-level scoreboard of expected results.
module tb_puf_scan_master;

    localparam int unsigned CHAL_W   = 128;
    localparam int unsigned DIV      = 2;
    localparam int unsigned EVAL_CYC = 16;
`ifdef PUF_MAJORITY_EN
    localparam int S = 3;
`else
    localparam int S = 1;
`endif

    logic              clk;
    logic              rstn;
    logic              start_i;
    logic [CHAL_W-1:0] chal_i;
    logic [1:0]        length_i;
    logic [1:0]        sel_i;
    logic              busy_o;
    logic              resp_valid_o;
    logic              resp_ready_i;
    logic              resp_bit_o;
    logic [CHAL_W-1:0] readback_o;
    logic              puf_clk_o;
    logic              puf_si_o;
    logic              puf_rstn_o;
    logic              puf_reset_o;
    logic [1:0]        puf_sel_o;
    logic [1:0]        puf_length_o;
    logic              puf_out_i;
    logic              puf_so_i;

    puf_scan_master #(
        .CHAL_W   (CHAL_W),
        .DIV      (DIV),
        .EVAL_CYC (EVAL_CYC)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start_i      (start_i),
        .chal_i       (chal_i),
        .length_i     (length_i),
        .sel_i        (sel_i),
        .busy_o       (busy_o),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_bit_o   (resp_bit_o),
        .readback_o   (readback_o),
        .puf_clk_o    (puf_clk_o),
        .puf_si_o     (puf_si_o),
        .puf_rstn_o   (puf_rstn_o),
        .puf_reset_o  (puf_reset_o),
        .puf_sel_o    (puf_sel_o),
        .puf_length_o (puf_length_o),
        .puf_out_i    (puf_out_i),
        .puf_so_i     (puf_so_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int bits_of(input logic [1:0] len);
        case (len)
            2'b00:   return 32;
            2'b01:   return 64;
            default: return 128;
        endcase
    endfunction

    function automatic logic [127:0] mask_of(input int n);
        logic [127:0] one;
        one = 128'd1;
        if (n >= 128) return '1;
        return (one << n) - 128'd1;
    endfunction

    // Response sampled from the 4-slot puf_out_i pattern: slot 1 alone, or slots 1..3 voted.
    function automatic logic exp_resp(input logic [3:0] p);
        if (S == 1) return p[1];
        return (p[1] & p[2]) | (p[1] & p[3]) | (p[2] & p[3]);
    endfunction

    // PUF chain model: shifts si in at bit 0 on each scan clock rise; so taps bit N-1.
    logic [127:0] tb_chain   = '0;
    logic [127:0] si_log     = '0;
    int           rise_total = 0;
    always @(posedge puf_clk_o) begin
        tb_chain   <= {tb_chain[126:0], puf_si_o};
        si_log     <= {si_log[126:0], puf_si_o};
        rise_total <= rise_total + 1;
    end
    assign puf_so_i = tb_chain[bits_of(puf_length_o) - 1];

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]   len;
        logic [127:0] chal;
        logic [1:0]   sel;
        logic [3:0]   pat;
        int           exp_n;
    } vec_t;

    typedef struct {
        logic         resp;
        logic [127:0] rb;
        logic [127:0] chal_m;
        int           n;
        int           lat;
        logic [1:0]   sel;
        logic [1:0]   len;
    } exp_t;

    exp_t         sb[$];
    logic [127:0] exp_chain = '0;

    task automatic run_op(input logic [1:0] len, input logic [127:0] chal, input logic [1:0] sel,
                          input logic [3:0] pat, input int hold, input int abort_at);
        exp_t e, got;
        int   lat_cnt, r0, idx;
        e.n      = bits_of(len);
        e.chal_m = chal & mask_of(e.n);
        e.rb     = exp_chain & mask_of(e.n);
        e.resp   = exp_resp(pat);
        e.lat    = 1 + 2 * e.n * int'(DIV) + 2 + int'(EVAL_CYC) + S;
        e.sel    = sel;
        e.len    = len;

        @(negedge clk);
        chal_i    = chal;
        length_i  = len;
        sel_i     = sel;
        start_i   = 1'b1;
        puf_out_i = ~e.resp;
        sb.push_back(e);
        exp_chain = (exp_chain << e.n) | e.chal_m;
        r0        = rise_total;
        @(negedge clk);
        start_i = 1'b0;
        chal_i  = '0;
        check("busy_after_accept", 128'(busy_o), 128'(1));

        lat_cnt = 0;
        while (!resp_valid_o && lat_cnt < 5000) begin
            if (abort_at > 0 && (rise_total - r0) == abort_at) begin
                rstn = 1'b0;
                #1;
                check("abort_puf_clk", 128'(puf_clk_o), 128'(0));
                check("abort_busy", 128'(busy_o), 128'(0));
                check("abort_puf_rstn", 128'(puf_rstn_o), 128'(0));
                check("abort_readback", readback_o, 128'(0));
                sb.delete();
                exp_chain = tb_chain;
                @(negedge clk);
                rstn = 1'b1;
                @(negedge clk);
                check("abort_rstn_release", 128'(puf_rstn_o), 128'(1));
                return;
            end
            idx = lat_cnt - (e.lat - S - 1);
            if (idx >= 0 && idx <= 3) puf_out_i = pat[idx];
            @(negedge clk);
            lat_cnt++;
        end
        check("latency", 128'(lat_cnt), 128'(e.lat));

        got = sb.pop_front();
        check("resp_bit", 128'(resp_bit_o), 128'(got.resp));
        check("readback", readback_o, got.rb);
        check("scan_rises", 128'(rise_total - r0), 128'(got.n));
        check("si_order", si_log & mask_of(got.n), got.chal_m);
        check("puf_sel", 128'(puf_sel_o), 128'(got.sel));
        check("puf_length", 128'(puf_length_o), 128'(got.len));

        for (int h = 0; h < hold; h++) begin
            puf_out_i = ~puf_out_i;
            start_i   = ~start_i;
            chal_i    = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(negedge clk);
            check("hold_valid", 128'(resp_valid_o), 128'(1));
            check("hold_bit", 128'(resp_bit_o), 128'(got.resp));
            check("hold_busy", 128'(busy_o), 128'(1));
            check("hold_readback", readback_o, got.rb);
        end
        start_i      = 1'b0;
        resp_ready_i = 1'b1;
        @(negedge clk);
        resp_ready_i = 1'b0;
        check("post_ready_valid", 128'(resp_valid_o), 128'(0));
        check("post_ready_busy", 128'(busy_o), 128'(0));
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{2'b00, 128'hA5A5_0F0F, 2'b01, 4'b1010, 32};
        vecs[1] = '{2'b01, 128'h0123_4567_89AB_CDEF, 2'b10, 4'b0101, 64};
        vecs[2] = '{2'b01, 128'hFEDC_BA98_7654_3210, 2'b11, 4'b0011, 64};
        vecs[3] = '{2'b10, 128'h8000_1234_5678_9ABC_DEF0_0FED_CBA9_8761, 2'b00, 4'b1110, 128};
        vecs[4] = '{2'b11, 128'h1357_9BDF_2468_ACE0_F0E1_D2C3_B4A5_9687, 2'b01, 4'b1010, 128};
        vecs[5] = '{2'b00, 128'hDEAD_BEEF_CAFE_F00D_1111_2222_FFFF_0001, 2'b10, 4'b0000, 32};

        rstn         = 1'b0;
        start_i      = 1'b0;
        chal_i       = '0;
        length_i     = '0;
        sel_i        = '0;
        resp_ready_i = 1'b0;
        puf_out_i    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              128'({busy_o, resp_valid_o, resp_bit_o, puf_clk_o, puf_si_o, puf_rstn_o,
                    puf_reset_o, puf_sel_o, puf_length_o}), 128'(0));
        check("reset_readback", readback_o, 128'(0));
        rstn = 1'b1;
        #1;
        check("puf_rstn_before_clk", 128'(puf_rstn_o), 128'(0));
        @(negedge clk);
        check("puf_rstn_after_clk", 128'(puf_rstn_o), 128'(1));
        check("idle_busy", 128'(busy_o), 128'(0));

        for (int i = 0; i < 6; i++) begin
            check("table_bits", 128'(bits_of(vecs[i].len)), 128'(vecs[i].exp_n));
            run_op(vecs[i].len, vecs[i].chal, vecs[i].sel, vecs[i].pat, 0, 0);
        end

        // Response held with consumer stalled; start pulses must be ignored.
        run_op(2'b00, 128'h0F0F_3C3C, 2'b11, 4'b1111, 10, 0);

        // Abort in the middle of a 128-bit shift, then rerun.
        run_op(2'b10, 128'hFFFF_0000_AAAA_5555_1234_5678_9ABC_DEF0, 2'b01, 4'b0101, 0, 17);
        check("abort_idle_busy", 128'(busy_o), 128'(0));
        run_op(2'b01, 128'hC3C3_A5A5_0FF0_9669, 2'b10, 4'b1010, 0, 0);
        run_op(2'b01, 128'h1122_3344_5566_7788, 2'b00, 4'b1100, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
